// File: rtl/wb_stream_reader.sv
// Wishbone classic read master: fetches a block of consecutive words, one bus
// cycle at a time, into a first-word-fall-through FIFO for a streaming consumer.

module wb_stream_reader_checker #(
    parameter int fifo_log2 = 4
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 push,
    input logic [fifo_log2:0]   level
);
    localparam logic [fifo_log2:0] depth_lvl = {1'b1, {fifo_log2{1'b0}}};

    // The fetch guard must never let a word arrive while the FIFO is full.
    push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && (level == depth_lvl)));
endmodule

module wb_stream_reader #(
    parameter int adr_width = 32,
    parameter int fifo_log2 = 4,
    parameter int len_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [adr_width-1:0] base_adr,
    input  logic [len_width-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [3:0]           wb_sel,
    output logic [adr_width-1:0] wb_adr,
    input  logic [31:0]          wb_dat_sm,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    input  logic                 wb_rty,
    input  logic                 rd_en,
    output logic [31:0]          rd_data,
    output logic                 empty,
    output logic [fifo_log2:0]   level
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int depth = 2 ** fifo_log2;
    localparam logic [fifo_log2:0]   depth_lvl = {1'b1, {fifo_log2{1'b0}}};
    localparam logic [fifo_log2:0]   depth_m1  = {1'b0, {fifo_log2{1'b1}}};
    localparam logic [fifo_log2:0]   lvl_one   = {{fifo_log2{1'b0}}, 1'b1};
    localparam logic [fifo_log2-1:0] ptr_one   = {{(fifo_log2-1){1'b0}}, 1'b1};
    localparam logic [len_width-1:0] cnt_one   = {{(len_width-1){1'b0}}, 1'b1};
    localparam logic [adr_width-1:0] adr_step  = {{(adr_width-3){1'b0}}, 3'b100};

    state_t               state_r, state_s;
    logic [adr_width-1:0] adr_r, adr_s;
    logic [len_width-1:0] cnt_r, cnt_s;
    logic                 busy_r, done_r, error_r, cyc_r;
    logic                 done_s, err_set_s, err_clr_s, push_s, pop_s;
    logic [fifo_log2:0]   level_r, level_s;
    logic [fifo_log2-1:0] wr_ptr_r, rd_ptr_r;
    logic [31:0]          mem_r [depth];

    // err outranks ack, so an erroring cycle never pushes.
    assign push_s = (state_r == FETCH) && wb_ack && !wb_err;
    assign pop_s  = rd_en && (level_r != {(fifo_log2+1){1'b0}});

    // Occupancy after this cycle's push and pop; also steers the fetch guard.
    always_comb begin
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + lvl_one;
            2'b01:   level_s = level_r - lvl_one;
            default: level_s = level_r;
        endcase
    end

    // Next-state logic with address/count bookkeeping.
    always_comb begin
        state_s   = state_r;
        adr_s     = adr_r;
        cnt_s     = cnt_r;
        done_s    = 1'b0;
        err_set_s = 1'b0;
        err_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    err_clr_s = 1'b1;
                    if (len != {len_width{1'b0}}) begin
                        adr_s   = {base_adr[adr_width-1:2], 2'b00};
                        cnt_s   = len;
                        state_s = (level_r < depth_lvl) ? FETCH : HOLD;
                    end else begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (wb_err) begin
                    err_set_s = 1'b1;
                    done_s    = 1'b1;
                    state_s   = FINISH;
                end else if (wb_ack) begin
                    adr_s = adr_r + adr_step;
                    cnt_s = cnt_r - cnt_one;
                    if (cnt_r == cnt_one) begin
                        done_s  = 1'b1;
                        state_s = FINISH;
                    end else if (level_s >= depth_m1) begin
                        state_s = HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end else if (wb_rty) begin
                    state_s = HOLD;
                end else begin
                    state_s = FETCH;
                end
            end
            HOLD: begin
                if (level_r < depth_lvl) begin
                    state_s = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state plus registered bus and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            adr_r   <= {adr_width{1'b0}};
            cnt_r   <= {len_width{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            cyc_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            adr_r   <= adr_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
            cyc_r   <= (state_s == FETCH);
            if (err_clr_s) begin
                error_r <= 1'b0;
            end else if (err_set_s) begin
                error_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {fifo_log2{1'b0}};
            rd_ptr_r <= {fifo_log2{1'b0}};
            level_r  <= {(fifo_log2+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_one;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_one;
            end
            level_r <= level_s;
        end
    end

    // FIFO storage, written only on an acknowledged read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wb_dat_sm;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;
    assign wb_cyc  = cyc_r;
    assign wb_stb  = cyc_r;
    assign wb_we   = 1'b0;
    assign wb_sel  = 4'hF;
    assign wb_adr  = adr_r;
    assign empty   = (level_r == {(fifo_log2+1){1'b0}});
    assign level   = level_r;
    assign rd_data = empty ? 32'h0000_0000 : mem_r[rd_ptr_r];

    wb_stream_reader_checker #(.fifo_log2(fifo_log2)) u_checker (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .level (level_r)
    );
endmodule

// File: doc/wb_stream_reader.md
Name: wb_stream_reader

Overview:
- Wishbone classic master that reads a block of consecutive 32-bit words from a Wishbone slave (block RAM or memory controller) and buffers them in an internal FIFO for a streaming consumer, e.g. a video pixel pipeline.
- Software or control logic supplies a byte base address and a word count, then pulses start.
- The block fetches words in order, one at a time, and never requests more than the FIFO can hold.

Parameters:
- adr_width, 32, width of the Wishbone byte address.
- fifo_log2, 4, log2 of the FIFO depth; depth = 2**fifo_log2 words.
- len_width, 16, width of the word-count input.

Ports:
- clk  in  1  system clock, shared with the Wishbone bus.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy.
- base_adr  in  adr_width  byte address of the first word; bits [1:0] ignored (treated as 0).
- len  in  len_width  number of words to read; 0 means the transfer completes immediately.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been pushed into the FIFO, or on abort.
- error  out  1  sticky error flag; set on wb_err, cleared by the next accepted start.
- wb_cyc, wb_stb  out  1  Wishbone cycle and strobe.
- wb_we  out  1  constant 0.
- wb_sel  out  4  constant 4'hF.
- wb_adr  out  adr_width  Wishbone byte address.
- wb_dat_sm  in  32  read data from the slave.
- wb_ack, wb_err, wb_rty  in  1  slave termination signals.
- rd_en  in  1  consumer pop request.
- rd_data  out  32  FIFO head word; valid while empty is 0.
- empty  out  1  FIFO empty.
- level  out  fifo_log2+1  number of words currently stored.

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE.
  - busy, done, error, wb_cyc, wb_stb all go to 0; wb_adr goes to 0.
  - FIFO is emptied: level=0, empty=1, rd_data=0.
  - An in-flight bus cycle is dropped immediately; the late ack is ignored.
- FSM states:
  - IDLE:
    - On start with len!=0: latch adr={base_adr[adr_width-1:2],2'b00} and cnt=len, clear error, go to FETCH.
    - On start with len==0: pulse done next cycle and stay in IDLE.
  - FETCH:
    - Entered only when level + 1 <= depth.
    - Drive wb_cyc=wb_stb=1 and wb_adr=adr; hold all of them stable until a termination is seen.
    - On wb_ack: push wb_dat_sm into the FIFO in the same edge, adr+=4 (wraps modulo 2**adr_width), cnt-=1.
    - After an ack: if cnt becomes 0, go to FINISH. Else if the FIFO holds depth-1 or more words after this push and pop, go to HOLD. Otherwise stay in FETCH and issue the next address on the following cycle (back-to-back; cyc/stb may stay high).
    - On wb_rty: deassert cyc/stb for one cycle (HOLD for one cycle), then retry the same address.
    - On wb_err: set error, drop cyc/stb, go to FINISH.
    - Priority if several terminations are asserted in one cycle: err, then ack, then rty.
  - HOLD: cyc=stb=0; return to FETCH when level < depth.
  - FINISH: cyc=stb=0; pulse done for 1 cycle; go to IDLE.
- busy is 1 in FETCH, HOLD and FINISH.
- Slave latency is arbitrary (0 to N cycles). A slave that acks one cycle after stb gives a throughput of one word per 2 cycles.
- FIFO:
  - Synchronous, first-word-fall-through: rd_data shows the head word combinationally from storage.
  - Push and pop in the same cycle are both performed and level is unchanged.
  - Pop while empty is ignored. Push while full cannot happen because of the FSM guard; an assertion checks this.
  - Pointers wrap modulo depth.
  - FIFO contents survive the end of a transfer; only reset clears them.

Test Plan:
- Single-cycle-ack slave, base=0x100, len=5, rd_en held at 1 → addresses 0x100, 0x104 … 0x110 issued in order; 5 words come out of the FIFO in address order; done pulses once; busy falls the cycle after done.
- rd_en=0, len=40, fifo_log2=4 → exactly 16 words fetched, then cyc stays 0 with level=16. Then pop 1 word → exactly one new fetch at 0x40 (base 0); level returns to 16.
- Slave waits 3 cycles before ack → wb_adr and stb stay stable across the wait; data is pushed only on the ack cycle.
- wb_err on the 3rd word of len=8 → error=1, done pulses, cyc drops, level=2. The next start clears error.
- wb_rty on the first word, then ack → cyc low for exactly 1 cycle, same address retried, word pushed once.
- rst asserted mid-transfer asynchronously (between clock edges) → cyc/stb/busy go to 0 immediately and empty=1. start with len=0 in IDLE → done pulses, no bus cycle.
